// File: rtl/sipo_word_deserializer.sv
// Serial-in/parallel-out word deserializer with a one-entry output holding
// register, frame resynchronisation and sticky overflow detection.
module sipo_word_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Ser_In,
  input  logic             Ser_Valid,
  input  logic             Frame_Start,
  output logic [WIDTH-1:0] Word_Out,
  output logic             Word_Valid,
  input  logic             Word_Ready,
  output logic             Overflow,
  input  logic             Clr_Ovf,
  output logic             o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_word;
  logic             r_ovf;

  logic [WIDTH-1:0] w_shift_word;
  logic [WIDTH-1:0] w_fs_word;
  logic             w_complete;
  logic             w_load;
  logic             w_ovf_set;

  // w_shift_word is the register contents after taking Ser_In; on the last
  // bit of a word it is also the completed word loaded into Word_Out.
  assign w_shift_word = MSB_FIRST ? {r_shreg[WIDTH-2:0], Ser_In}
                                  : {Ser_In, r_shreg[WIDTH-1:1]};
  assign w_fs_word    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, Ser_In}
                                  : {Ser_In, {(WIDTH-1){1'b0}}};
  assign w_complete   = Ser_Valid & ~Frame_Start & (r_cnt == LAST_CNT);

  // Serial side: every valid bit is accepted, Frame_Start restarts the word.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (Frame_Start) begin
      r_shreg <= Ser_Valid ? w_fs_word : '0;
      r_cnt   <= Ser_Valid ? CW'(1) : '0;
    end else if (Ser_Valid) begin
      r_shreg <= w_shift_word;
      r_cnt   <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output handshake: a word transfers on a posedge where Word_Valid and
  // Word_Ready are both high; Word_Out is frozen while valid and not ready,
  // and a word completing into a full, stalled register is dropped.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_complete) begin
          w_load       = 1'b1;
          w_next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_complete) begin
          if (Word_Ready) begin
            w_load = 1'b1;
          end else begin
            w_ovf_set = 1'b1;
          end
        end else if (Word_Ready) begin
          w_next_state = ST_EMPTY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_word <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) begin
        r_word <= w_shift_word;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (Clr_Ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign Word_Out    = r_word;
  assign Word_Valid  = (r_state == ST_FULL);
  assign Overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sipo_word_deserializer.sv
// Self-checking bench for sipo_word_deserializer: MSB-first and LSB-first
// instances share stimulus and are checked against a bit-list reference model.
module tb_sipo_word_deserializer;

  localparam int W = 4;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic         Ser_In, Ser_Valid, Frame_Start, Word_Ready, Clr_Ovf;
  logic [W-1:0] word_m, word_l;
  logic         valid_m, valid_l, ovf_m, ovf_l, dbg_m, dbg_l;

  sipo_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .Rst(Rst), .Ser_In(Ser_In), .Ser_Valid(Ser_Valid),
    .Frame_Start(Frame_Start), .Word_Out(word_m), .Word_Valid(valid_m),
    .Word_Ready(Word_Ready), .Overflow(ovf_m), .Clr_Ovf(Clr_Ovf),
    .o_dbg_state(dbg_m)
  );

  sipo_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk(Clk), .Rst(Rst), .Ser_In(Ser_In), .Ser_Valid(Ser_Valid),
    .Frame_Start(Frame_Start), .Word_Out(word_l), .Word_Valid(valid_l),
    .Word_Ready(Word_Ready), .Overflow(ovf_l), .Clr_Ovf(Clr_Ovf),
    .o_dbg_state(dbg_l)
  );

  int total = 0;
  int bad   = 0;

  // reference model: partial word kept as a list of received bits
  bit           m_bits[$];
  logic         m_valid;
  logic         m_ovf;
  logic [W-1:0] m_word_m;
  logic [W-1:0] m_word_l;

  task automatic model_reset();
    m_bits.delete();
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_word_m = '0;
    m_word_l = '0;
  endtask

  task automatic model_step(input logic sv, fs, b, rdy, clr);
    bit done = 1'b0;
    bit ovf_set = 1'b0;
    int nm = 0;
    int nl = 0;
    if (fs) begin
      m_bits.delete();
      if (sv) m_bits.push_back(b);
    end else if (sv) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (m_bits[i]) begin
            nm = nm + (1 << (W - 1 - i));
            nl = nl + (1 << i);
          end
        end
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid  = 1'b1;
        m_word_m = W'(nm);
        m_word_l = W'(nl);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid_m"}, 32'(valid_m), 32'(m_valid));
    chk({tag, ".word_m"},  32'(word_m),  32'(m_word_m));
    chk({tag, ".ovf_m"},   32'(ovf_m),   32'(m_ovf));
    chk({tag, ".valid_l"}, 32'(valid_l), 32'(m_valid));
    chk({tag, ".word_l"},  32'(word_l),  32'(m_word_l));
    chk({tag, ".ovf_l"},   32'(ovf_l),   32'(m_ovf));
  endtask

  // driver: inputs change 1 time unit after a posedge, outputs sampled there too
  task automatic step(input logic sv, fs, b, rdy, clr, input string tag);
    Ser_Valid   = sv;
    Frame_Start = fs;
    Ser_In      = b;
    Word_Ready  = rdy;
    Clr_Ovf     = clr;
    @(posedge Clk);
    model_step(sv, fs, b, rdy, clr);
    #1;
    chk_model(tag);
  endtask

  task automatic send_bits(input logic [W-1:0] bits_msb_first, input logic rdy, input string tag);
    for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b0, bits_msb_first[i], rdy, 1'b0, tag);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #3;
    model_reset();
    chk("reset.valid", 32'(valid_m), 32'd0);
    chk("reset.word",  32'(word_m),  32'd0);
    chk("reset.ovf",   32'(ovf_m),   32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  typedef struct {
    logic         sv, fs, b, rdy, clr;
    logic         exp_v;
    logic [W-1:0] exp_w;
    logic         exp_o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic sv, fs, b, rdy, clr, ev, input logic [W-1:0] ew, input logic eo);
    vec_t v;
    v.sv = sv; v.fs = fs; v.b = b; v.rdy = rdy; v.clr = clr;
    v.exp_v = ev; v.exp_w = ew; v.exp_o = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // stall/overflow/clear table on the MSB-first instance, from reset
    add(1,0,1,0,0, 0,4'h0,0); add(1,0,0,0,0, 0,4'h0,0);
    add(1,0,1,0,0, 0,4'h0,0); add(1,0,0,0,0, 1,4'hA,0);
    add(1,0,0,0,0, 1,4'hA,0); add(1,0,1,0,0, 1,4'hA,0);
    add(1,0,0,0,0, 1,4'hA,0); add(1,0,1,0,0, 1,4'hA,1);
    add(0,0,0,1,0, 0,4'hA,1); add(0,0,0,0,1, 0,4'hA,0);
    add(1,0,1,0,0, 0,4'hA,0); add(1,0,1,0,0, 0,4'hA,0);
    add(1,0,1,0,0, 0,4'hA,0); add(1,0,1,0,0, 1,4'hF,0);
    add(1,0,0,0,0, 1,4'hF,0); add(1,0,0,0,0, 1,4'hF,0);
    add(1,0,0,0,0, 1,4'hF,0); add(1,0,0,0,1, 1,4'hF,1);
    add(0,0,0,1,1, 0,4'hF,0);

    Ser_In = 0; Ser_Valid = 0; Frame_Start = 0; Word_Ready = 0; Clr_Ovf = 0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    do_reset();

    foreach (tbl[k]) begin
      step(tbl[k].sv, tbl[k].fs, tbl[k].b, tbl[k].rdy, tbl[k].clr, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.valid", k), 32'(valid_m), 32'(tbl[k].exp_v));
      chk($sformatf("tbl%0d.word", k),  32'(word_m),  32'(tbl[k].exp_w));
      chk($sformatf("tbl%0d.ovf", k),   32'(ovf_m),   32'(tbl[k].exp_o));
    end

    // reset mid-stream with a held word: cleared without a clock edge
    send_bits(4'h3, 1'b0, "pre_rst");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "mid0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid1");
    #2;
    Rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.valid", 32'(valid_m), 32'd0);
    chk("async_rst.word",  32'(word_m),  32'd0);
    chk("async_rst.word_l", 32'(word_l), 32'd0);
    #1;
    Rst = 1'b0;
    send_bits(4'hB, 1'b1, "after_rst");
    chk("after_rst.word_m", 32'(word_m), 32'hB);
    chk("after_rst.word_l", 32'(word_l), 32'hD);
    chk("after_rst.valid", 32'(valid_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain");
    chk("drain.valid", 32'(valid_m), 32'd0);

    // back-to-back reload: completion while full and Word_Ready high
    send_bits(4'hF, 1'b1, "b2b_a");
    chk("b2b_a.word", 32'(word_m), 32'hF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_hold");
    chk("b2b_hold.valid", 32'(valid_m), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "b2b_b");
    chk("b2b_b.valid", 32'(valid_m), 32'd1);
    chk("b2b_b.word",  32'(word_m),  32'h1);
    chk("b2b_b.ovf",   32'(ovf_m),   32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_drain");

    // frame resync discards a partial word
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fs0");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fs1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "fs2");
    chk("fs2.valid", 32'(valid_m), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fs3");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fs4");
    chk("fs4.valid", 32'(valid_m), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "fs5");
    chk("fs5.word_m", 32'(word_m), 32'h6);
    chk("fs5.word_l", 32'(word_l), 32'h6);
    chk("fs5.valid", 32'(valid_m), 32'd1);

    // gapped input: three idle cycles between bits
    for (int i = W - 1; i >= 0; i--) begin
      logic [W-1:0] pat;
      pat = 4'h9;
      step(1'b1, 1'b0, pat[i], 1'b1, 1'b0, "gap_bit");
      if (i != 0) begin
        for (int j = 0; j < 3; j++) begin
          step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "gap_idle");
          chk("gap_idle.valid", 32'(valid_m), 32'd0);
        end
      end
    end
    chk("gap.word_m", 32'(word_m), 32'h9);
    chk("gap.word_l", 32'(word_l), 32'h9);
    chk("gap.valid", 32'(valid_m), 32'd1);

    // randomized stimulus against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_word_deserializer.md
Name: sipo_word_deserializer

Overview:
Serial-in/parallel-out deserializer that assembles WIDTH-bit words from a 1-bit serial stream and presents them to the downstream 4-bit register bank on its D input through a valid/ready output handshake. It includes a one-entry output holding register, frame resynchronisation and sticky overflow detection. Single clock domain.

Parameters:
WIDTH, 4, word width in bits (>=2); drives the 4-bit register-bank input at default
MSB_FIRST, 1, 1 = first serial bit of a word lands in Word_Out[WIDTH-1]; 0 = first bit lands in Word_Out[0]

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  asynchronous, active-high reset
Ser_In  input  1  serial data bit
Ser_Valid  input  1  Ser_In is valid this cycle; bit is always accepted (no backpressure on serial side)
Frame_Start  input  1  resync: current cycle starts a new word, any partial word discarded
Word_Out  output  WIDTH  assembled word, held stable while Word_Valid=1 and Word_Ready=0
Word_Valid  output  1  Word_Out holds an undelivered word
Word_Ready  input  1  downstream accepts the word; transfer when Word_Valid & Word_Ready at posedge
Overflow  output  1  sticky: a completed word was dropped because the holding register was occupied
Clr_Ovf  input  1  synchronous clear of Overflow

Behaviour:
- Reset (async, Rst=1): bit counter=0, shift register=0, Word_Out=0, Word_Valid=0, Overflow=0. Takes effect immediately, independent of Clk; partial word and held word both lost.
- Bit counter cnt in 0..WIDTH-1, width $clog2(WIDTH).
- Ser_Valid=1, Frame_Start=0: bit shifted in (MSB_FIRST=1: shift left, new bit at LSB; MSB_FIRST=0: shift right, new bit at MSB); cnt increments; at cnt=WIDTH-1, cnt wraps to 0 and word completes.
- Ser_Valid=1, Frame_Start=1: shift register cleared, the bit is taken as bit 0 of the new word, cnt=1 (for WIDTH=2 this is not a completion).
- Ser_Valid=0, Frame_Start=1: cnt=0, shift register cleared, no word produced.
- Ser_Valid=0, Frame_Start=0: no change to shift register or cnt.
- Output FSM, two states:
  - EMPTY (Word_Valid=0): on completion -> load Word_Out with the assembled word including the final bit -> FULL.
  - FULL (Word_Valid=1): Word_Ready=1 and no completion -> EMPTY. Word_Ready=1 with completion in the same cycle -> load the new word, stay FULL (back-to-back, no bubble). Word_Ready=0 with completion -> new word dropped, Word_Out unchanged, Overflow<=1.
- Latency: Word_Valid rises at the same posedge that samples the final bit. At the default WIDTH, one word per 4 accepted bits, sustained.
- Overflow: set as above; Clr_Ovf=1 clears it. If a set and a clear occur in the same cycle, the set wins.
- Word_Out is updated only on load, never while FULL-and-stalled.

Test Plan:
- Reset mid-stream: shift 2 bits, assert Rst between edges -> Word_Valid=0, Word_Out=0 immediately; the next 4 bits 1,0,1,1 -> Word_Out=4'hB.
- MSB_FIRST=1, Word_Ready=1: bits 1,0,1,1 -> Word_Valid=1 after the 4th bit edge, Word_Out=4'hB, then Word_Valid=0 next cycle. With MSB_FIRST=0, same bits -> 4'hD.
- Back-to-back: continuous Ser_Valid with bits 1,1,1,1,0,0,0,1 and Word_Ready=1 -> 4'hF then 4'h1 on consecutive word boundaries; Word_Valid stays high across the reload.
- Stall/overflow: Word_Ready=0, send 4'hA then 4'h5 -> Word_Out stays 4'hA, Overflow=1; raise Word_Ready -> 4'hA delivered, Word_Valid=0. Then Clr_Ovf=1 -> Overflow=0. Set and clear in the same cycle -> Overflow=1.
- Frame resync: send bits 1,1, then Frame_Start=1 with Ser_Valid=1 and bit 0, followed by bits 1,1,0 -> Word_Out=4'h6, partial word discarded.
- Gapped input: bits 1,0,0,1 with Ser_Valid low 3 cycles between each -> Word_Out=4'h9, no spurious Word_Valid during gaps.
